// File: rtl/aoi_sweep_checker.sv
// Purpose: exhaustive in-fabric sweep of an external AND/OR-invert gate, checked against a golden model.
// Latency: one vector per clock; done pulses 2^N_IN + LAT clocks after the start is accepted.
// Backpressure: none; start is honoured only in IDLE, and extra starts or mode changes while busy are dropped.
//
// Ports:
//   clk, rst_n     clock (rising edge) and asynchronous active-low reset
//   start, mode    sweep request and gate mode (00 AOI, 01 OAI, 10 AND-OR, 11 OR-AND), latched on accept
//   dut_in         registered stimulus vector to the gate under test, bit 0 toggles fastest
//   dut_out        gate response, expected LAT clocks after the vector appears on dut_in
//   busy, done     sweep in progress / one-cycle completion pulse
//   err_cnt        saturating mismatch count for the current sweep
//   first_err_vld  at least one mismatch seen; first_err_vec holds the vector of the first one
//   pass           set with done when the sweep saw no mismatch, held until the next accept
module aoi_sweep_checker #(
  parameter int N_IN  = 4,  // gate inputs, 2..16
  parameter int GROUP = 2,  // inputs per AND/OR term, must divide N_IN
  parameter int LAT   = 1,  // gate response latency in clocks, 1..4
  parameter int ERR_W = 8   // mismatch counter width
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       mode,
  output logic [N_IN-1:0]  dut_in,
  input  logic             dut_out,
  output logic             busy,
  output logic             done,
  output logic [ERR_W-1:0] err_cnt,
  output logic             first_err_vld,
  output logic [N_IN-1:0]  first_err_vec,
  output logic             pass
);

  localparam int N_GRP = N_IN / GROUP;
  // One spare bit on the vector counter so the terminal value is unambiguous.
  localparam int CNT_W = N_IN + 1;
  localparam logic [CNT_W-1:0] LAST_VEC   = {1'b0, {N_IN{1'b1}}};
  localparam logic [2:0]       DRAIN_LAST = 3'(LAT - 1);
  localparam logic [ERR_W-1:0] ERR_MAX    = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    DRAIN = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    MODE_AOI    = 2'b00,
    MODE_OAI    = 2'b01,
    MODE_AND_OR = 2'b10,
    MODE_OR_AND = 2'b11
  } mode_t;

  state_t state;
  state_t state_nxt;
  mode_t  mode_q;

  logic [CNT_W-1:0] vec_cnt;
  logic [2:0]       drain_cnt;

  // FSM control strobes
  logic accept;
  logic run_step;
  logic push;
  logic finish;

  // Golden model
  logic and_or;
  logic or_and;
  logic exp_bit;

  // Expected-response pipeline, LAT deep, each entry tagged valid
  logic [LAT-1:0]  pipe_vld;
  logic [LAT-1:0]  pipe_exp;
  logic [N_IN-1:0] pipe_vec [LAT];

  logic cmp_vld;
  logic mismatch;

  assign dut_in = vec_cnt[N_IN-1:0];
  assign busy   = (state != IDLE);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and control strobes
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    run_step  = 1'b0;
    push      = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        // The vector on dut_in this cycle enters the expectation pipeline.
        push = 1'b1;
        if (vec_cnt == LAST_VEC) begin
          state_nxt = DRAIN;
        end else begin
          run_step = 1'b1;
        end
      end
      DRAIN: begin
        // The final compare lands on the same edge that leaves DRAIN.
        if (drain_cnt == DRAIN_LAST) begin
          finish    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Golden model of the gate for the vector currently on dut_in
  // ---------------------------------------------------------------------------
  always_comb begin
    and_or = 1'b0;
    or_and = 1'b1;
    for (int j = 0; j < N_GRP; j++) begin
      and_or = and_or | (&dut_in[j*GROUP +: GROUP]);
      or_and = or_and & (|dut_in[j*GROUP +: GROUP]);
    end
    case (mode_q)
      MODE_AOI:    exp_bit = ~and_or;
      MODE_OAI:    exp_bit = ~or_and;
      MODE_AND_OR: exp_bit = and_or;
      MODE_OR_AND: exp_bit = or_and;
      default:     exp_bit = ~and_or;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Expectation pipeline: an entry reaches the last stage in the same cycle
  // the gate's response to that vector is on dut_out.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld <= '0;
      pipe_exp <= '0;
      for (int i = 0; i < LAT; i++) begin
        pipe_vec[i] <= '0;
      end
    end else begin
      pipe_vld[0] <= push;
      pipe_exp[0] <= exp_bit;
      pipe_vec[0] <= dut_in;
      for (int i = 1; i < LAT; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_exp[i] <= pipe_exp[i-1];
        pipe_vec[i] <= pipe_vec[i-1];
      end
    end
  end

  assign cmp_vld  = pipe_vld[LAT-1];
  assign mismatch = cmp_vld && (dut_out != pipe_exp[LAT-1]);

  // ---------------------------------------------------------------------------
  // Sweep datapath: vector counter, drain timer, result registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q        <= MODE_AOI;
      vec_cnt       <= '0;
      drain_cnt     <= '0;
      done          <= 1'b0;
      err_cnt       <= '0;
      first_err_vld <= 1'b0;
      first_err_vec <= '0;
      pass          <= 1'b0;
    end else begin
      done <= finish;

      // Drain timer restarts every RUN cycle so it is at zero on DRAIN entry.
      if (state == RUN) begin
        drain_cnt <= '0;
      end else if (state == DRAIN) begin
        drain_cnt <= drain_cnt + 3'd1;
      end

      if (accept) begin
        mode_q        <= mode_t'(mode);
        vec_cnt       <= '0;
        err_cnt       <= '0;
        first_err_vld <= 1'b0;
        first_err_vec <= '0;
        pass          <= 1'b0;
      end else begin
        if (run_step) begin
          vec_cnt <= vec_cnt + CNT_W'(1);
        end

        if (mismatch) begin
          if (err_cnt != ERR_MAX) begin
            err_cnt <= err_cnt + ERR_W'(1);
          end
          if (!first_err_vld) begin
            first_err_vld <= 1'b1;
            first_err_vec <= pipe_vec[LAT-1];
          end
        end

        // Include a mismatch on the final compare, which shares this edge.
        if (finish) begin
          pass <= ~(first_err_vld | mismatch);
        end
      end
    end
  end

endmodule

// File: tb/tb_aoi_sweep_checker.sv
`timescale 1ns/1ps
module tb_aoi_sweep_checker;

  localparam int NDUT = 3;   // dut0: LAT1 ERR_W8, dut1: LAT1 ERR_W2, dut2: LAT3 ERR_W8
  localparam int NI   = 4;
  localparam int NV   = 1 << NI;

  typedef struct {
    int     cnt;
    int     fvec;
    bit     fvld;
    bit     pass;
    longint done_cyc;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  logic [NDUT-1:0]         start   = '0;
  logic [NDUT-1:0][1:0]    mode_in = '0;
  logic [NDUT-1:0][NI-1:0] din;
  logic [NDUT-1:0]         gout;
  logic [NDUT-1:0]         busy;
  logic [NDUT-1:0]         done;
  logic [NDUT-1:0]         fvld;
  logic [NDUT-1:0]         pass_o;
  logic [NDUT-1:0][NI-1:0] fvec;
  logic [NDUT-1:0][7:0]    ecnt;
  logic [1:0]              ecnt_b;

  // Gate under test model: kind 0 correct, 1 tied 1, 2 tied 0, 3 inverted, 4 random flips
  int              g_mode [NDUT];
  int              g_kind [NDUT];
  logic [NV-1:0]   g_mask [NDUT];
  logic [NDUT-1:0][3:0] gpipe = '0;

  longint cyc = 0;
  int n_chk  = 0;
  int n_pass = 0;

  exp_t sb [NDUT][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aoi_sweep_checker #(.N_IN(4), .GROUP(2), .LAT(1), .ERR_W(8)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .mode(mode_in[0]), .dut_in(din[0]),
    .dut_out(gout[0]), .busy(busy[0]), .done(done[0]), .err_cnt(ecnt[0]),
    .first_err_vld(fvld[0]), .first_err_vec(fvec[0]), .pass(pass_o[0]));

  aoi_sweep_checker #(.N_IN(4), .GROUP(2), .LAT(1), .ERR_W(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .mode(mode_in[1]), .dut_in(din[1]),
    .dut_out(gout[1]), .busy(busy[1]), .done(done[1]), .err_cnt(ecnt_b),
    .first_err_vld(fvld[1]), .first_err_vec(fvec[1]), .pass(pass_o[1]));

  aoi_sweep_checker #(.N_IN(4), .GROUP(2), .LAT(3), .ERR_W(8)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .mode(mode_in[2]), .dut_in(din[2]),
    .dut_out(gout[2]), .busy(busy[2]), .done(done[2]), .err_cnt(ecnt[2]),
    .first_err_vld(fvld[2]), .first_err_vec(fvec[2]), .pass(pass_o[2]));

  assign ecnt[1] = {6'b0, ecnt_b};

  function automatic int lat_of(input int i);
    return (i == 2) ? 3 : 1;
  endfunction

  function automatic int maxcnt_of(input int i);
    return (i == 1) ? 3 : 255;
  endfunction

  // Ideal gate: the 4-bit vector is two 2-bit groups
  function automatic bit gate_fn(input int m, input int v);
    bit ao;
    bit oa;
    int grp;
    ao = 1'b0;
    oa = 1'b1;
    for (int j = 0; j < NI / 2; j++) begin
      grp = (v >> (2 * j)) & 3;
      ao  = ao | (grp == 3);
      oa  = oa & (grp != 0);
    end
    case (m)
      0:       return !ao;
      1:       return !oa;
      2:       return ao;
      default: return oa;
    endcase
  endfunction

  function automatic bit gate_resp(input int i, input int v);
    case (g_kind[i])
      0:       return gate_fn(g_mode[i], v);
      1:       return 1'b1;
      2:       return 1'b0;
      3:       return !gate_fn(g_mode[i], v);
      default: return gate_fn(g_mode[i], v) ^ g_mask[i][v];
    endcase
  endfunction

  function automatic exp_t build_exp(input int i, input longint k);
    exp_t e;
    e.cnt  = 0;
    e.fvec = 0;
    e.fvld = 1'b0;
    for (int v = 0; v < NV; v++) begin
      if (gate_resp(i, v) != gate_fn(g_mode[i], v)) begin
        if (!e.fvld) begin
          e.fvld = 1'b1;
          e.fvec = v;
        end
        if (e.cnt < maxcnt_of(i)) e.cnt++;
      end
    end
    e.pass     = !e.fvld;
    e.done_cyc = k + NV + lat_of(i);
    return e;
  endfunction

  // Gate registers: response to the vector on dut_in appears LAT clocks later
  always @(posedge clk) begin
    for (int i = 0; i < NDUT; i++) begin
      gpipe[i] <= {gpipe[i][2:0], gate_resp(i, int'(din[i]))};
    end
  end
  assign gout[0] = gpipe[0][0];
  assign gout[1] = gpipe[1][0];
  assign gout[2] = gpipe[2][2];

  task automatic chk(input string name, input int i, input longint act, input longint req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s dut%0d: got %0d, expected %0d (cycle %0d)", name, i, act, req, cyc);
  endtask

  // Monitor: pops the scoreboard whenever a DUT signals done
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      for (int i = 0; i < NDUT; i++) begin
        if (done[i]) begin
          n_chk++;
          if (sb[i].size() == 0) begin
            $display("FAIL done_unexpected dut%0d: got done at cycle %0d, expected none", i, cyc);
          end else begin
            n_pass++;
            e = sb[i].pop_front();
            chk("done_cycle", i, cyc, e.done_cyc);
            chk("busy_at_done", i, longint'(busy[i]), 0);
            chk("err_cnt", i, longint'(ecnt[i]), e.cnt);
            chk("first_err_vld", i, longint'(fvld[i]), e.fvld);
            chk("first_err_vec", i, longint'(fvec[i]), e.fvec);
            chk("pass", i, longint'(pass_o[i]), e.pass);
            chk("dut_in_hold", i, longint'(din[i]), NV - 1);
          end
        end
      end
    end
  end

  task automatic launch(input logic [NDUT-1:0] which);
    @(negedge clk);
    for (int i = 0; i < NDUT; i++) begin
      if (which[i]) begin
        start[i]   = 1'b1;
        mode_in[i] = 2'(g_mode[i]);
      end
    end
    @(negedge clk);
    start = '0;
    for (int i = 0; i < NDUT; i++) begin
      if (which[i]) sb[i].push_back(build_exp(i, cyc));
    end
  endtask

  // Waits for all outstanding sweeps; with noise, pokes start and mode while busy
  task automatic wait_all(input bit noise);
    int guard;
    guard = 0;
    while ((sb[0].size() + sb[1].size() + sb[2].size()) != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
      start = '0;
      if (noise) begin
        for (int i = 0; i < NDUT; i++) begin
          if (busy[i]) begin
            if ($urandom_range(0, 2) == 0) start[i] = 1'b1;
            mode_in[i] = 2'($urandom_range(0, 3));
          end
        end
      end
    end
    n_chk++;
    if (guard < 200) n_pass++;
    else $display("FAIL sweep_timeout: got %0d pending after %0d cycles, expected 0", sb[0].size() + sb[1].size() + sb[2].size(), guard);
    @(negedge clk);
    start = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at cycle %0d, expected finish", cyc);
    $fatal(1);
  end

  initial begin
    int guard;
    for (int i = 0; i < NDUT; i++) begin
      g_mode[i] = 0;
      g_kind[i] = 0;
      g_mask[i] = '0;
    end

    // Reset values
    repeat (3) @(negedge clk);
    for (int i = 0; i < NDUT; i++) begin
      chk("rst_dut_in", i, longint'(din[i]), 0);
      chk("rst_busy", i, longint'(busy[i]), 0);
      chk("rst_done", i, longint'(done[i]), 0);
      chk("rst_err_cnt", i, longint'(ecnt[i]), 0);
      chk("rst_first_err_vld", i, longint'(fvld[i]), 0);
      chk("rst_first_err_vec", i, longint'(fvec[i]), 0);
      chk("rst_pass", i, longint'(pass_o[i]), 0);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Clean AOI on dut0, inverted gate saturating dut1, clean LAT=3 with noise on dut2
    g_mode[0] = 0; g_kind[0] = 0;
    g_mode[1] = 0; g_kind[1] = 3;
    g_mode[2] = 0; g_kind[2] = 0;
    launch(3'b111);
    wait_all(1'b1);

    // Tied-1 AOI, tied-0 OAI into a 2-bit counter, random flips in OR-AND at LAT=3
    g_mode[0] = 0; g_kind[0] = 1;
    g_mode[1] = 1; g_kind[1] = 2;
    g_mode[2] = 3; g_kind[2] = 4; g_mask[2] = NV'($urandom);
    launch(3'b111);
    wait_all(1'b1);

    // Tied-0 OAI, then a new start accepted while done is high
    g_mode[0] = 1; g_kind[0] = 2;
    launch(3'b001);
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!done[0] && guard < 40);
    chk("b2b_done_seen", 0, longint'(done[0]), 1);
    g_mode[0] = 2; g_kind[0] = 4; g_mask[0] = NV'($urandom);
    start[0] = 1'b1;
    mode_in[0] = 2'(g_mode[0]);
    @(negedge clk);
    start[0] = 1'b0;
    sb[0].push_back(build_exp(0, cyc));
    wait_all(1'b0);

    // Asynchronous reset mid-sweep, then a clean sweep
    g_mode[0] = 0; g_kind[0] = 1;
    launch(3'b001);
    guard = 0;
    while (din[0] != 4'd8 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    chk("pre_rst_dut_in", 0, longint'(din[0]), 8);
    chk("pre_rst_err_cnt", 0, longint'(ecnt[0]), 1);
    chk("pre_rst_first_err_vec", 0, longint'(fvec[0]), 3);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_dut_in", 0, longint'(din[0]), 0);
    chk("arst_busy", 0, longint'(busy[0]), 0);
    chk("arst_err_cnt", 0, longint'(ecnt[0]), 0);
    chk("arst_first_err_vld", 0, longint'(fvld[0]), 0);
    sb[0].delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("post_rst_busy", 0, longint'(busy[0]), 0);
    g_kind[0] = 0;
    launch(3'b001);
    wait_all(1'b0);

    // Randomized sweeps on random subsets of the instances
    repeat (12) begin
      for (int i = 0; i < NDUT; i++) begin
        g_mode[i] = int'($urandom_range(0, 3));
        g_kind[i] = int'($urandom_range(0, 4));
        g_mask[i] = NV'($urandom);
      end
      launch(3'($urandom_range(1, 7)));
      wait_all(1'b1);
    end

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/aoi_sweep_checker.md
# aoi_sweep_checker

Parametrised self-checking sweep engine for and-or-invert style gates. On a start request it drives every one of the 2^N_IN input combinations to an external gate under test, one vector per clock. It compares the gate's response against an internal golden model in any of four and/or modes, with a configurable response latency. It reports a saturating mismatch count, the first failing vector and a pass flag, and replaces free-running toggle stimulus with an exhaustive, cycle-exact, in-fabric check.

## Interface
Parameters:
- N_IN, 4, number of gate inputs; legal range 2..16.
- GROUP, 2, inputs per AND/OR term; must divide N_IN.
- LAT, 1, gate response latency in clocks; legal range 1..4.
- ERR_W, 8, width of the mismatch counter.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  sweep request; sampled only in IDLE.
- mode  in  2  00 AOI, 01 OAI, 10 AND-OR, 11 OR-AND; latched on start accept.
- dut_in  out  N_IN  registered stimulus vector; bit 0 toggles fastest.
- dut_out  in  1  gate response.
- busy  out  1  high from start accept until done.
- done  out  1  one-cycle pulse after the last compare.
- err_cnt  out  ERR_W  mismatches; saturates at 2^ERR_W-1.
- first_err_vld  out  1  at least one mismatch seen this sweep.
- first_err_vec  out  N_IN  vector of the first mismatch; 0 if none.
- pass  out  1  set with done when err_cnt==0; held until the next start accept.

## Operation
- FSM states:
  - IDLE: start=1 moves to RUN.
  - RUN: stays while the vector counter is below 2^N_IN-1, then moves to DRAIN.
  - DRAIN: runs LAT cycles, then returns to IDLE with the done pulse.
- Start accept clears err_cnt, first_err_vld, first_err_vec and pass, latches mode, and loads dut_in=0.
- The vector counter is N_IN+1 bits wide, so there is no wrap ambiguity. dut_in increments once per clock in RUN and holds its last value in DRAIN and IDLE.
- Golden model: group j is dut_in[j*GROUP +: GROUP].
  - AND-OR = OR over j of (AND of group j).
  - OR-AND = AND over j of (OR of group j).
  - AOI = ~AND-OR; OAI = ~OR-AND.
- The expected bit and its vector travel through a LAT-deep valid-tagged shift register. The compare happens when a valid entry emerges.
- On a mismatch, err_cnt increments unless it is saturated. If first_err_vld=0, first_err_vec captures the vector and first_err_vld is set.
- start while busy is ignored. Mode changes while busy are ignored.
- Reset values: dut_in=0, busy=0, done=0, err_cnt=0, first_err_vld=0, first_err_vec=0, pass=0, FSM=IDLE, pipeline valids=0.

## Timing
- Start accepted at edge k: busy=1 and dut_in=0 from edge k.
- Vector v is present from edge k+v. Its response is sampled at edge k+v+LAT.
- The last compare is at edge k+2^N_IN-1+LAT.
- done=1 for exactly one cycle from edge k+2^N_IN+LAT. busy falls and pass updates at the same edge.
- A new start can be accepted at the edge after done, i.e. while done=1 and busy=0.
- A mismatch on the final compare is still counted before done.
- Reset mid-sweep: all outputs immediately take their reset values, with no done pulse and no stale compare after release.

## Test plan
- N_IN=4, GROUP=2, LAT=1, mode AOI, dut_out from a correct AOI gate with one register -> done at edge k+17, err_cnt=0, first_err_vld=0, pass=1.
- Same configuration, dut_out tied 1 -> err_cnt=7, first_err_vec=4'b0011, pass=0.
- Mode OAI, dut_out tied 0 -> err_cnt=7, first_err_vec=4'b0000.
- ERR_W=2, dut_out = inverted correct response -> err_cnt saturates at 3 (not 0), first_err_vec=0, pass=0.
- rst_n pulsed low while dut_in=8 -> dut_in, busy and err_cnt read 0 asynchronously and no done follows. A subsequent start runs a full clean sweep with pass=1.
- LAT=3 with correct registered gate, extra start pulses while busy -> single done at edge k+19, pass=1, and the extra starts are ignored.
